// File: rtl/multicast_tree_1_n_seq.sv
// 1-to-N pipelined distribution tree with per-word destination mask and subtree pruning; latency NUM_LEVEL+1 cycles.
// Backpressure: global lockstep stall when i_en=0 or any valid output is not ready; o_in_ready mirrors the advance.
module multicast_tree_1_n_seq #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTPUT_DATA = 8,
    localparam int NUM_LEVEL      = $clog2(NUM_OUTPUT_DATA)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    input  logic [DATA_WIDTH-1:0]                 i_data_bus,
    input  logic [NUM_OUTPUT_DATA-1:0]            i_dest_mask,
    input  logic                                  i_en,
    input  logic [NUM_OUTPUT_DATA-1:0]            i_out_ready,
    output logic                                  o_in_ready,
    output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
    output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
    output logic                                  o_busy,
    output logic                                  o_drop
);

    localparam int N  = NUM_OUTPUT_DATA;
    localparam int DW = DATA_WIDTH;

    // Internal tree nodes packed level by level: level k starts at node (1<<k)-1.
    // Each level keeps a full N-bit mask; a node's slice is zero whenever the node is invalid.
    logic [N-2:0]           vld_q, vld_d;
    logic [(N-1)*DW-1:0]    dat_q, dat_d;
    logic [NUM_LEVEL*N-1:0] msk_q, msk_d;
    logic [N-1:0]           out_vld_q, out_vld_d;
    logic [N*DW-1:0]        out_dat_q, out_dat_d;
    logic                   drop_q, drop_d;
    logic                   adv;

    assign adv        = i_en & ~|(out_vld_q & ~i_out_ready);
    assign o_in_ready = adv;

    always_comb begin
        vld_d     = '0;
        dat_d     = '0;
        msk_d     = '0;
        out_vld_d = '0;
        out_dat_d = '0;
        drop_d    = adv & i_valid & ~|i_dest_mask;

        vld_d[0] = i_valid & |i_dest_mask;
        if (vld_d[0]) begin
            dat_d[0 +: DW] = i_data_bus;
            msk_d[0 +: N]  = i_dest_mask;
        end

        for (int k = 1; k < NUM_LEVEL; k++) begin
            for (int b = 0; b < N; b++) begin
                int n;
                int p;
                n = b >> (NUM_LEVEL - k);
                p = n >> 1;
                if (vld_q[(1 << (k - 1)) - 1 + p] && msk_q[(k - 1) * N + b]) begin
                    vld_d[(1 << k) - 1 + n]              = 1'b1;
                    msk_d[k * N + b]                     = 1'b1;
                    dat_d[((1 << k) - 1 + n) * DW +: DW] =
                        dat_q[((1 << (k - 1)) - 1 + p) * DW +: DW];
                end
            end
        end

        for (int p = 0; p < N; p++) begin
            int par;
            par = (1 << (NUM_LEVEL - 1)) - 1 + (p >> 1);
            if (vld_q[par] && msk_q[(NUM_LEVEL - 1) * N + p]) begin
                out_vld_d[p]             = 1'b1;
                out_dat_d[p * DW +: DW]  = dat_q[par * DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q     <= '0;
            dat_q     <= '0;
            msk_q     <= '0;
            out_vld_q <= '0;
            out_dat_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= drop_d;
            if (adv) begin
                vld_q     <= vld_d;
                dat_q     <= dat_d;
                msk_q     <= msk_d;
                out_vld_q <= out_vld_d;
                out_dat_q <= out_dat_d;
            end
        end
    end

    assign o_valid    = out_vld_q;
    assign o_data_bus = out_dat_q;
    assign o_busy     = |vld_q | |out_vld_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_multicast_tree_1_n_seq.sv
// Directed bench for multicast_tree_1_n_seq with N=8, DATA_WIDTH=32.
module tb_multicast_tree_1_n_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic [31:0]  i_data_bus;
    logic [7:0]   i_dest_mask;
    logic         i_en;
    logic [7:0]   i_out_ready;
    logic         o_in_ready;
    logic [7:0]   o_valid;
    logic [255:0] o_data_bus;
    logic         o_busy;
    logic         o_drop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicast_tree_1_n_seq #(.DATA_WIDTH(32), .NUM_OUTPUT_DATA(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_data_bus  (i_data_bus),
        .i_dest_mask (i_dest_mask),
        .i_en        (i_en),
        .i_out_ready (i_out_ready),
        .o_in_ready  (o_in_ready),
        .o_valid     (o_valid),
        .o_data_bus  (o_data_bus),
        .o_busy      (o_busy),
        .o_drop      (o_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] lanes(input logic [7:0] m, input logic [31:0] d);
        logic [255:0] r;
        r = '0;
        for (int p = 0; p < 8; p++)
            if (m[p]) r[p*32 +: 32] = d;
        return r;
    endfunction

    initial begin
        int expw [1:13];
        int nxt;
        logic exp_rdy;
        logic [7:0] em;
        logic [31:0] ed;

        // reset state
        rst = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_dest_mask = '0;
        i_en = 1'b0; i_out_ready = 8'hFF;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data_bus, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_inrdy_en0", o_in_ready, 0);
        i_en = 1'b1;
        #1;
        chk("inrdy_en1", o_in_ready, 1);

        // broadcast
        i_valid = 1'b1; i_data_bus = 32'hDEADBEEF; i_dest_mask = 8'hFF;
        for (int c = 1; c <= 5; c++) begin
            tick();
            i_valid = 1'b0; i_data_bus = '0; i_dest_mask = '0;
            chk($sformatf("bc_valid_c%0d", c), o_valid, (c == 4) ? 8'hFF : 8'h00);
            chk($sformatf("bc_data_c%0d", c), o_data_bus,
                (c == 4) ? lanes(8'hFF, 32'hDEADBEEF) : 256'h0);
            chk($sformatf("bc_busy_c%0d", c), o_busy, (c <= 4) ? 1'b1 : 1'b0);
        end

        // unicast then multicast back to back
        i_valid = 1'b1; i_data_bus = 32'hA5; i_dest_mask = 8'h01;
        tick();
        i_data_bus = 32'h5A; i_dest_mask = 8'h90;
        tick();
        i_valid = 1'b0; i_data_bus = '0; i_dest_mask = '0;
        tick(); tick();
        chk("uni_valid", o_valid, 8'h01);
        chk("uni_data", o_data_bus, lanes(8'h01, 32'hA5));
        tick();
        chk("multi_valid", o_valid, 8'h90);
        chk("multi_data", o_data_bus, lanes(8'h90, 32'h5A));
        tick();
        chk("multi_after", o_valid, 8'h00);

        // backpressure on lane 3 while word 1 sits at the output
        expw = '{0, 0, 0, 1, 1, 1, 1, 2, 3, 4, 5, 6, 0};
        nxt = 1;
        for (int e = 1; e <= 13; e++) begin
            exp_rdy = !(e >= 5 && e <= 7);
            i_out_ready = exp_rdy ? 8'hFF : 8'hF7;
            i_valid = (nxt <= 6);
            i_data_bus = (nxt <= 6) ? 32'(nxt) : 32'h0;
            i_dest_mask = (nxt <= 6) ? 8'hFF : 8'h00;
            #1;
            chk($sformatf("bp_inrdy_e%0d", e), o_in_ready, exp_rdy);
            if (i_valid && exp_rdy) nxt++;
            tick();
            chk($sformatf("bp_valid_e%0d", e), o_valid, (expw[e] != 0) ? 8'hFF : 8'h00);
            chk($sformatf("bp_data_e%0d", e), o_data_bus,
                (expw[e] != 0) ? lanes(8'hFF, 32'(expw[e])) : 256'h0);
        end
        i_valid = 1'b0; i_data_bus = '0; i_dest_mask = '0; i_out_ready = 8'hFF;

        // i_en stall of 2 cycles while two words are in flight
        for (int e = 1; e <= 8; e++) begin
            i_en = !(e == 2 || e == 3);
            i_valid = (e == 1 || e == 4);
            i_data_bus = (e == 1) ? 32'h77 : (e == 4) ? 32'h88 : 32'h0;
            i_dest_mask = (e == 1) ? 8'h3C : (e == 4) ? 8'h81 : 8'h00;
            #1;
            chk($sformatf("en_inrdy_e%0d", e), o_in_ready, i_en);
            tick();
            em = (e == 6) ? 8'h3C : (e == 7) ? 8'h81 : 8'h00;
            ed = (e == 6) ? 32'h77 : (e == 7) ? 32'h88 : 32'h0;
            chk($sformatf("en_valid_e%0d", e), o_valid, em);
            chk($sformatf("en_data_e%0d", e), o_data_bus, lanes(em, ed));
        end
        i_en = 1'b1; i_valid = 1'b0; i_data_bus = '0; i_dest_mask = '0;

        // zero mask is dropped
        i_valid = 1'b1; i_data_bus = 32'h1234; i_dest_mask = 8'h00;
        tick();
        i_valid = 1'b0; i_data_bus = '0;
        chk("zm_drop", o_drop, 1);
        chk("zm_busy", o_busy, 0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("zm_drop_c%0d", c), o_drop, 0);
            chk($sformatf("zm_valid_c%0d", c), o_valid, 0);
        end

        // reset with three words in flight, i_en low
        for (int c = 1; c <= 3; c++) begin
            i_valid = 1'b1; i_data_bus = 32'(c * 32'h11); i_dest_mask = 8'hFF;
            tick();
        end
        i_valid = 1'b0; i_data_bus = '0; i_dest_mask = '0;
        rst = 1'b0; i_en = 1'b0;
        tick();
        chk("mr_valid", o_valid, 0);
        chk("mr_data", o_data_bus, 0);
        chk("mr_busy", o_busy, 0);
        rst = 1'b1; i_en = 1'b1;
        i_valid = 1'b1; i_data_bus = 32'h44; i_dest_mask = 8'h0F;
        for (int c = 1; c <= 5; c++) begin
            tick();
            i_valid = 1'b0; i_data_bus = '0; i_dest_mask = '0;
            chk($sformatf("mr_post_valid_c%0d", c), o_valid, (c == 4) ? 8'h0F : 8'h00);
            chk($sformatf("mr_post_data_c%0d", c), o_data_bus,
                (c == 4) ? lanes(8'h0F, 32'h44) : 256'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicast_tree_1_n_seq.md
Name: multicast_tree_1_n_seq

Overview:
- Parametrised, pipelined 1-to-N distribution tree with per-packet destination mask (unicast/multicast/broadcast) and valid/ready backpressure.
- One register stage per tree level plus an output stage. Empty subtrees are pruned: their valid is low and their data is zeroed.
- Global stall via i_en or downstream not-ready. Holds state; never flushes.
- Sits at the input side of the non-hierarchical crossbar and feeds N output ports or merge trees.

Parameters:
- DATA_WIDTH, 32, bits per data word; any value >= 1.
- NUM_OUTPUT_DATA, 8, number of leaves; power of 2, >= 2.
- NUM_LEVEL, $clog2(NUM_OUTPUT_DATA), derived localparam; do not override.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low; reset when rst==0 at posedge.
- i_valid  input  1  input word valid.
- i_data_bus  input  DATA_WIDTH  input word.
- i_dest_mask  input  NUM_OUTPUT_DATA  destination bitmap; bit p targets output p.
- i_en  input  1  pipeline enable; 0 = stall/hold.
- i_out_ready  input  NUM_OUTPUT_DATA  per-output consumer ready.
- o_in_ready  output  1  block can accept the input word this cycle.
- o_valid  output  NUM_OUTPUT_DATA  per-output valid, registered.
- o_data_bus  output  NUM_OUTPUT_DATA*DATA_WIDTH  output p occupies bits [p*DATA_WIDTH +: DATA_WIDTH]; registered.
- o_busy  output  1  high when any stage holds a valid word.
- o_drop  output  1  one-cycle pulse: word accepted with an all-zero mask and discarded.

Behaviour:
- Reset: all stage valids, data and masks clear to 0. o_valid=0, o_data_bus=0, o_drop=0, o_busy=0. o_in_ready is combinational and follows the adv rule below.
- Pipeline stages:
  - Stage 0: 1 node.
  - Stage k (1..NUM_LEVEL-1): 2^k nodes.
  - Output stage: NUM_OUTPUT_DATA leaves.
  - Each node holds data, valid, and the mask slice for its subtree.
  - Node j at stage k+1 takes from parent j>>1; child 2j receives the lower half of the parent's mask slice, child 2j+1 the upper half.
- Pruning:
  - Node valid = parent valid AND |(node mask slice).
  - Node data = parent data when node valid, else 0.
  - Leaf p: o_valid[p] = valid AND mask[p].
- Advance: adv = i_en AND NOT |(o_valid & ~i_out_ready).
  - All stages move together when adv=1 and hold everything when adv=0 (global lockstep stall, no bubbles collapsed).
  - o_in_ready = adv.
- Accept: transfer occurs when i_valid & o_in_ready. Stage 0 then loads valid = |i_dest_mask, data and mask.
- When adv=1 and i_valid=0, stage 0 loads valid=0 and data=0.
- Latency: accepted word appears on o_valid/o_data_bus exactly NUM_LEVEL+1 cycles after the accept edge if there is no stall. Stall cycles add 1:1.
- Output hold: o_valid/o_data_bus remain stable while adv=0. A leaf is consumed only on a cycle with adv=1.
  - Multicast outputs therefore complete atomically: all targeted outputs must be ready in the same cycle.
- Drop: accepted word with i_dest_mask==0 raises o_drop for the cycle after acceptance. It is never emitted and never occupies a valid slot.
- Throughput: 1 word/cycle when always ready.
- Mid-operation reset: rst==0 clears all in-flight words on that edge regardless of i_en. The next accepted word behaves as after power-up.
- o_busy = OR of all stage valids including the output stage; registered-state-derived only.
- Simultaneous accept and output consume in one cycle is legal and keeps full rate.

Test Plan:
- Broadcast, N=8, DATA_WIDTH=32: reset, i_en=1, all ready, i_valid=1, data 0xDEADBEEF, mask 0xFF for one cycle -> 4 cycles later o_valid=0xFF, every lane 0xDEADBEEF, for 1 cycle; o_busy high cycles 1-4.
- Unicast/multicast pruning: mask 0x01 data 0xA5 then mask 0x90 data 0x5A back-to-back -> o_valid=0x01 (lane0=0xA5, others 0), then o_valid=0x90 (lanes 4,7=0x5A, others 0) on consecutive cycles.
- Backpressure: stream 6 words (data 1..6, mask 0xFF); hold i_out_ready[3]=0 for 3 cycles when word 1 reaches the output -> o_in_ready low those 3 cycles, word 1 held stable, no loss or duplication; order 1..6 preserved.
- i_en stall: drop i_en for 2 cycles mid-stream -> all stages hold, latency extends by exactly 2, data intact.
- Zero mask: i_valid=1, mask 0x00, data 0x1234 -> o_drop pulses 1 cycle after accept; no o_valid ever asserted.
- Reset mid-flight: 3 words in flight, rst=0 for one cycle -> next edge o_valid=0, o_data_bus=0, o_busy=0; following word emerges after 4 cycles.
